// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: arbitrates RESET > NMI > IRQ > BRK at an
// instruction boundary, then walks the fixed 7-step entry and drives stack/vector
// control to the datapath.
module interrupt_sequencer #(
  parameter logic [15:0] VecNmi   = 16'hFFFA,
  parameter logic [15:0] VecReset = 16'hFFFC,
  parameter logic [15:0] VecIrq   = 16'hFFFE,
  parameter bit          HijackEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_ffs_i,
  input  logic        reset_detected_i,
  input  logic        nmi_generated_i,
  input  logic        irq_generated_i,
  input  logic        brk_decoded_i,
  input  logic        instr_boundary_i,
  output logic        seq_active_o,
  output logic [2:0]  seq_step_o,
  output logic        push_enable_o,
  output logic [1:0]  push_sel_o,
  output logic        stack_dec_o,
  output logic        b_flag_value_o,
  output logic [15:0] vector_addr_o,
  output logic        load_pcl_o,
  output logic        load_pch_o,
  output logic        set_i_flag_o,
  output logic        interrupt_started_o
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StDum0 = 3'd1,
    StDum1 = 3'd2,
    StPshH = 3'd3,
    StPshL = 3'd4,
    StPshP = 3'd5,
    StVecL = 3'd6,
    StVecH = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    SrcNone  = 3'd0,
    SrcReset = 3'd1,
    SrcNmi   = 3'd2,
    SrcIrq   = 3'd3,
    SrcBrk   = 3'd4
  } src_e;

  state_e state_q, state_d;
  src_e   src_q, src_d;
  // Remembers that the entry began as BRK, so a hijack to NMI keeps B=1 in the pushed P.
  logic   brk_q, brk_d;

  logic        in_push_window;
  logic [15:0] vec_base;

  assign in_push_window = (state_q == StDum0) || (state_q == StDum1) ||
                          (state_q == StPshH) || (state_q == StPshL) ||
                          (state_q == StPshP);

  // Next-state: arbitration in IDLE, fixed walk otherwise, with reset abort and NMI hijack.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    brk_d   = brk_q;
    if (enable_ffs_i) begin
      unique case (state_q)
        StIdle: begin
          if (instr_boundary_i) begin
            if (reset_detected_i) begin
              state_d = StDum0;
              src_d   = SrcReset;
              brk_d   = 1'b0;
            end else if (nmi_generated_i) begin
              state_d = StDum0;
              src_d   = SrcNmi;
              brk_d   = 1'b0;
            end else if (irq_generated_i) begin
              state_d = StDum0;
              src_d   = SrcIrq;
              brk_d   = 1'b0;
            end else if (brk_decoded_i) begin
              state_d = StDum0;
              src_d   = SrcBrk;
              brk_d   = 1'b1;
            end
          end
        end
        default: begin
          // A reset entry already in flight is not restarted by its own pending request.
          if (reset_detected_i && (src_q != SrcReset)) begin
            state_d = StDum0;
            src_d   = SrcReset;
            brk_d   = 1'b0;
          end else if (state_q == StVecH) begin
            state_d = StIdle;
            src_d   = SrcNone;
            brk_d   = 1'b0;
          end else begin
            state_d = state_e'(state_q + 3'd1);
            if (HijackEn && nmi_generated_i && in_push_window &&
                ((src_q == SrcIrq) || (src_q == SrcBrk))) begin
              src_d = SrcNmi;
            end
          end
        end
      endcase
    end
  end

  // State and source latch registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= SrcNone;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      brk_q   <= brk_d;
    end
  end

  // Vector base selected by the (possibly hijacked) source.
  always_comb begin
    vec_base = VecIrq;
    if (src_q == SrcNmi) begin
      vec_base = VecNmi;
    end else if (src_q == SrcReset) begin
      vec_base = VecReset;
    end
  end

  // Output decode of the registered state and source.
  always_comb begin
    seq_active_o        = (state_q != StIdle);
    seq_step_o          = state_q;
    push_enable_o       = 1'b0;
    push_sel_o          = 2'b00;
    stack_dec_o         = 1'b0;
    b_flag_value_o      = 1'b0;
    vector_addr_o       = 16'h0000;
    load_pcl_o          = 1'b0;
    load_pch_o          = 1'b0;
    set_i_flag_o        = 1'b0;
    interrupt_started_o = 1'b0;
    unique case (state_q)
      StPshH: begin
        stack_dec_o   = 1'b1;
        push_enable_o = (src_q != SrcReset);
        push_sel_o    = 2'b00;
      end
      StPshL: begin
        stack_dec_o   = 1'b1;
        push_enable_o = (src_q != SrcReset);
        push_sel_o    = 2'b01;
      end
      StPshP: begin
        stack_dec_o    = 1'b1;
        // Reset performs dummy reads: SP still decrements but nothing is written.
        push_enable_o  = (src_q != SrcReset);
        push_sel_o     = 2'b10;
        b_flag_value_o = brk_q;
      end
      StVecL: begin
        vector_addr_o       = vec_base;
        load_pcl_o          = 1'b1;
        set_i_flag_o        = 1'b1;
        // Gated by the enable so a stalled VEC_L acknowledges exactly once.
        interrupt_started_o = enable_ffs_i;
      end
      StVecH: begin
        vector_addr_o = vec_base + 16'd1;
        load_pch_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: walks each entry type step by step against
// hand-derived output vectors.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rst_det;
  logic        nmi;
  logic        irq;
  logic        brk;
  logic        bnd;
  logic        seq_active;
  logic [2:0]  seq_step;
  logic        push_enable;
  logic [1:0]  push_sel;
  logic        stack_dec;
  logic        b_flag;
  logic [15:0] vector_addr;
  logic        load_pcl;
  logic        load_pch;
  logic        set_i;
  logic        int_started;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // {active, step, push_en, push_sel, stack_dec, b_flag, vector, ld_pcl, ld_pch, set_i, started}
  logic [28:0] obs;
  assign obs = {seq_active, seq_step, push_enable, push_sel, stack_dec, b_flag, vector_addr,
                load_pcl, load_pch, set_i, int_started};

  interrupt_sequencer dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .enable_ffs_i       (en),
    .reset_detected_i   (rst_det),
    .nmi_generated_i    (nmi),
    .irq_generated_i    (irq),
    .brk_decoded_i      (brk),
    .instr_boundary_i   (bnd),
    .seq_active_o       (seq_active),
    .seq_step_o         (seq_step),
    .push_enable_o      (push_enable),
    .push_sel_o         (push_sel),
    .stack_dec_o        (stack_dec),
    .b_flag_value_o     (b_flag),
    .vector_addr_o      (vector_addr),
    .load_pcl_o         (load_pcl),
    .load_pch_o         (load_pch),
    .set_i_flag_o       (set_i),
    .interrupt_started_o(int_started)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output vector for a given step; push/vector details hand-derived per step.
  function automatic logic [28:0] exp_out(input int s, input bit is_rst, input bit is_brk,
                                          input logic [15:0] vec, input bit en_v);
    logic [28:0] v;
    v = '0;
    case (s)
      1: v = {1'b1, 3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 4'b0000};
      2: v = {1'b1, 3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 4'b0000};
      3: v = {1'b1, 3'd3, !is_rst, 2'b00, 1'b1, 1'b0, 16'h0000, 4'b0000};
      4: v = {1'b1, 3'd4, !is_rst, 2'b01, 1'b1, 1'b0, 16'h0000, 4'b0000};
      5: v = {1'b1, 3'd5, !is_rst, 2'b10, 1'b1, is_brk, 16'h0000, 4'b0000};
      6: v = {1'b1, 3'd6, 1'b0, 2'b00, 1'b0, 1'b0, vec, 1'b1, 1'b0, 1'b1, en_v};
      7: v = {1'b1, 3'd7, 1'b0, 2'b00, 1'b0, 1'b0, vec + 16'd1, 4'b0100};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Checks steps first..last, one per enabled clock; starts at a negedge in step 'first'.
  task automatic walk(input string tag, input int first, input int last, input bit is_rst,
                      input bit is_brk, input logic [15:0] vec);
    for (int s = first; s <= last; s++) begin
      check_eq($sformatf("%s_s%0d", tag, s), 32'(obs), 32'(exp_out(s, is_rst, is_brk, vec, 1'b1)));
      @(negedge clk);
    end
  endtask

  // Presents the pending sources with a boundary for one edge; ends at a negedge in DUM0.
  task automatic start(input string tag, input bit r, input bit n, input bit i, input bit b);
    rst_det = r;
    nmi     = n;
    irq     = i;
    brk     = b;
    bnd     = 1'b1;
    check_eq({tag, "_idle"}, 32'(obs), 32'd0);
    @(negedge clk);
    rst_det = 1'b0;
    nmi     = 1'b0;
    irq     = 1'b0;
    brk     = 1'b0;
    bnd     = 1'b0;
  endtask

  int active_cnt;
  int pulse_cnt;
  logic [15:0] seen_vec;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    rst_det = 1'b0;
    nmi     = 1'b0;
    irq     = 1'b0;
    brk     = 1'b0;
    bnd     = 1'b0;
    #2;
    check_eq("reset_outs", 32'(obs), 32'd0);
    // Pending request during reset must not advance anything.
    irq = 1'b1;
    bnd = 1'b1;
    @(negedge clk);
    check_eq("reset_hold", 32'(obs), 32'd0);
    irq   = 1'b0;
    bnd   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_no_req", 32'(obs), 32'd0);

    // Pending source without a boundary stays idle.
    irq = 1'b1;
    @(negedge clk);
    check_eq("no_boundary", 32'(obs), 32'd0);
    irq = 1'b0;

    // 1: IRQ entry.
    start("irq", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("irq", 1, 7, 1'b0, 1'b0, 16'hFFFE);
    check_eq("irq_end", 32'(obs), 32'd0);

    // 2: BRK entry, B=1 in pushed P.
    start("brk", 1'b0, 1'b0, 1'b0, 1'b1);
    walk("brk", 1, 7, 1'b0, 1'b1, 16'hFFFE);
    check_eq("brk_end", 32'(obs), 32'd0);

    // 3: RESET beats NMI; no writes, SP still decrements.
    start("rst", 1'b1, 1'b1, 1'b0, 1'b0);
    walk("rst", 1, 7, 1'b1, 1'b0, 16'hFFFC);
    check_eq("rst_end", 32'(obs), 32'd0);

    // NMI beats IRQ and BRK.
    start("nmi", 1'b0, 1'b1, 1'b1, 1'b1);
    walk("nmi", 1, 7, 1'b0, 1'b0, 16'hFFFA);

    // 4a: NMI in PSH_L hijacks IRQ vector.
    start("hij", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("hij", 1, 3, 1'b0, 1'b0, 16'hFFFE);
    nmi = 1'b1;
    walk("hij", 4, 7, 1'b0, 1'b0, 16'hFFFA);
    nmi = 1'b0;
    check_eq("hij_end", 32'(obs), 32'd0);

    // Hijacked BRK keeps B=1 but vectors to NMI.
    start("hbrk", 1'b0, 1'b0, 1'b0, 1'b1);
    nmi = 1'b1;
    walk("hbrk", 1, 7, 1'b0, 1'b1, 16'hFFFA);
    nmi = 1'b0;

    // 4b: NMI first seen in VEC_L does not hijack, then waits for a boundary.
    start("late", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("late", 1, 5, 1'b0, 1'b0, 16'hFFFE);
    nmi = 1'b1;
    walk("late", 6, 7, 1'b0, 1'b0, 16'hFFFE);
    check_eq("late_wait", 32'(obs), 32'd0);
    @(negedge clk);
    check_eq("late_wait2", 32'(obs), 32'd0);
    start("late2", 1'b0, 1'b1, 1'b0, 1'b0);
    walk("late2", 1, 7, 1'b0, 1'b0, 16'hFFFA);

    // 5: enable toggling through an NMI entry.
    start("en", 1'b0, 1'b1, 1'b0, 1'b0);
    en         = 1'b0;
    active_cnt = 0;
    pulse_cnt  = 0;
    seen_vec   = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      if (seq_active) active_cnt++;
      if (int_started) pulse_cnt++;
      if (load_pcl) seen_vec = vector_addr;
      if (!seq_active) break;
      @(negedge clk);
      en = ~en;
    end
    en = 1'b1;
    check_eq("en_active_cycles", 32'(active_cnt), 32'd14);
    check_eq("en_started_pulses", 32'(pulse_cnt), 32'd1);
    check_eq("en_vector", 32'(seen_vec), 32'hFFFA);

    // 6a: async reset in PSH_P clears outputs immediately.
    start("arst", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("arst", 1, 4, 1'b0, 1'b0, 16'hFFFE);
    check_eq("arst_s5", 32'(obs), 32'(exp_out(5, 1'b0, 1'b0, 16'hFFFE, 1'b1)));
    #1 rst_n = 1'b0;
    #1 check_eq("arst_clear", 32'(obs), 32'd0);
    @(negedge clk);
    check_eq("arst_held", 32'(obs), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 6b: resetDetected in DUM1 restarts as RESET.
    start("abort", 1'b0, 1'b0, 1'b1, 1'b0);
    walk("abort", 1, 1, 1'b0, 1'b0, 16'hFFFE);
    rst_det = 1'b1;
    check_eq("abort_s2", 32'(obs), 32'(exp_out(2, 1'b0, 1'b0, 16'hFFFE, 1'b1)));
    @(negedge clk);
    rst_det = 1'b0;
    walk("abort", 1, 7, 1'b1, 1'b0, 16'hFFFC);
    check_eq("abort_end", 32'(obs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
